adder_share_arbiter: RTL and testbench
======================================

# adder_share_arbiter

Arbitrates a single shared 32-bit adder between two requesters: for example, PC increment and branch/ALU operand generation. It steers each requester's operand pair through the existing `mux_32` operand selectors. It registers the operands, performs one addition per grant and returns a registered sum with a one-cycle done pulse. It sits between the fetch/execute control logic and the adder datapath, and is the only block allowed to drive the adder operand selectors.

## Interface
- `WIDTH`, default 32: operand and result width.
- `clk` input 1: system clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `req0` input 1: request from requester 0. Held high with operands stable until `gnt0`.
- `a0` input WIDTH: operand A, requester 0.
- `b0` input WIDTH: operand B, requester 0.
- `req1` input 1: request from requester 1. Same rules as `req0`.
- `a1` input WIDTH: operand A, requester 1.
- `b1` input WIDTH: operand B, requester 1.
- `gnt0` output 1: one-cycle grant pulse to requester 0.
- `gnt1` output 1: one-cycle grant pulse to requester 1.
- `done0` output 1: one-cycle pulse; `result` is valid for requester 0.
- `done1` output 1: one-cycle pulse; `result` is valid for requester 1.
- `result` output WIDTH: registered sum, held until the next done.
- `carry_out` output 1: carry out of the MSB of the last sum.
- `busy` output 1: high whenever the FSM is not in IDLE.

## Operation
- FSM states: IDLE, GRANT, EXEC, DONE.
  - IDLE → GRANT when `req0` or `req1` is high at a clock edge.
  - GRANT → EXEC unconditionally.
  - EXEC → DONE unconditionally.
  - DONE → IDLE unconditionally.
- Winner selection, evaluated in IDLE:
  - If only one request is high, that requester wins.
  - If both are high, round-robin picks the requester not served last.
  - The `last` pointer resets to 1, so `req0` wins the first tie.
- The winner is latched into the `sel` register on the IDLE → GRANT edge. `sel` drives both operand muxes for the rest of the operation. `sel` = 0 selects `a0`/`b0`; `sel` = 1 selects `a1`/`b1`.
- GRANT:
  - `gnt_sel` is high for this state only.
  - At the GRANT → EXEC edge, operand registers capture the mux outputs.
- EXEC:
  - The adder computes `opA + opB` combinationally at WIDTH+1 bits.
  - At the EXEC → DONE edge, `result` takes the low WIDTH bits (wrap modulo 2^WIDTH) and `carry_out` takes bit WIDTH.
- DONE:
  - `done_sel` is high for this state only.
  - `last` is updated to `sel` on the DONE → IDLE edge.
- Boundary conditions:
  - A request dropped before its grant is simply not served.
  - A request dropped after its grant does not abort the operation; done still pulses.
  - A requester still holding `req` in the IDLE after its DONE is treated as a new request, subject to round-robin.
  - No preemption: a request arriving while `busy` waits for IDLE.
- Reset (`reset` low, any state, takes effect immediately):
  - State = IDLE, `last` = 1, `sel` = 0.
  - Operand registers = 0.
  - `gnt0`, `gnt1`, `done0`, `done1`, `busy` = 0; `result` = 0; `carry_out` = 0.
  - An in-flight operation is discarded and produces no done pulse.

## Timing
- Let E0 be the edge at which IDLE samples a request.
- Cycle E0–E1: gnt high, `busy` high.
- E1: operands captured.
- E2: result registered.
- Cycle E2–E3: done high.
- E3: FSM returns to IDLE.
- E4: earliest next arbitration.
- Latency from request sample to done is 2 cycles; throughput is one addition per 4 cycles.
- All outputs are registered or decoded from state registers only; there is no combinational path from `req*`/`a*`/`b*` to any output.

## Structure
- Shared package holds:
  - state encoding constants `ST_IDLE`, `ST_GRANT`, `ST_EXEC`, `ST_DONE` (2 bits);
  - requester index constants `REQ0` = 0, `REQ1` = 1;
  - default `WIDTH` = 32.
- Sub-module: two instances of `mux_32` (operand A, operand B), both driven by `sel` on their selector input.
- FSM, round-robin pointer, operand/result registers and the adder live in the top level.

## Test plan
- Reset: hold `reset` low for 5 cycles with `req0` = `req1` = 1 → all outputs 0, no grant.
- Single request: `req0` = 1, `a0` = 40, `b0` = 50 → `gnt0` at cycle 1, `done0` at cycle 3, `result` = 90, `carry_out` = 0, `done1`/`gnt1` never high.
- Simultaneous first request: both requests from reset, `a0` = 40, `b0` = 50, `a1` = 7, `b1` = 8 → requester 0 served first (90), then `done1` four cycles later with `result` = 15.
- Overflow: `a0` = 32'hFFFFFFFF, `b0` = 1 → `result` = 0, `carry_out` = 1.
- Reset mid-operation: pull `reset` low during EXEC → outputs 0 immediately, no done. After release, a `req1` with 7 + 8 completes normally with `result` = 15.
- Fairness: `req0` and `req1` held high for 16 cycles → grants alternate 0, 1, 0, 1, giving exactly two done pulses each.

Source files
------------

// File: rtl/adder_share_arbiter_pkg.sv
// Shared constants and types for the shared-adder arbiter: state encoding,
// requester indices and the default datapath width.
package adder_share_arbiter_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_EXEC  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    localparam int unsigned DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        StIdle  = ST_IDLE,
        StGrant = ST_GRANT,
        StExec  = ST_EXEC,
        StDone  = ST_DONE
    } state_e;

endpackage

// File: rtl/adder_share_arbiter_if.sv
// Requester-side bundle of the shared adder: two request/operand channels in,
// grant/done pulses and the registered sum out.
interface adder_share_arbiter_if
    import adder_share_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
);
    logic             req0;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    logic             req1;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic             gnt0;
    logic             gnt1;
    logic             done0;
    logic             done1;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             busy;

    modport master (
        output req0, a0, b0, req1, a1, b1,
        input  gnt0, gnt1, done0, done1, result, carry_out, busy
    );

    modport slave (
        input  req0, a0, b0, req1, a1, b1,
        output gnt0, gnt1, done0, done1, result, carry_out, busy
    );

endinterface

// File: rtl/mux_32.sv
// Two-input operand selector: sel = 0 passes in0, sel = 1 passes in1.
module mux_32 #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             sel,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    output logic [WIDTH-1:0] out
);

    assign out = sel ? in1 : in0;

endmodule

// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter that time-shares one WIDTH-bit adder between two requesters;
// one registered addition per grant, result returned with a one-cycle done pulse.
module adder_share_arbiter
    import adder_share_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    adder_share_arbiter_if.slave  bus
);

    state_e           state_q, state_d;
    logic             sel_q, sel_d;
    logic             last_q, last_d;
    logic [WIDTH-1:0] op_a_q, op_b_q;
    logic [WIDTH-1:0] mux_a, mux_b;
    logic [WIDTH-1:0] result_q;
    logic             carry_q;
    logic [WIDTH:0]   sum;

    mux_32 #(.WIDTH(WIDTH)) u_mux_a (
        .sel (sel_q),
        .in0 (bus.a0),
        .in1 (bus.a1),
        .out (mux_a)
    );

    mux_32 #(.WIDTH(WIDTH)) u_mux_b (
        .sel (sel_q),
        .in0 (bus.b0),
        .in1 (bus.b1),
        .out (mux_b)
    );

    assign sum = {1'b0, op_a_q} + {1'b0, op_b_q};

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        unique case (state_q)
            StIdle: begin
                if (bus.req0 || bus.req1) begin
                    state_d = StGrant;
                    // On a tie, serve whoever was not served last.
                    if (bus.req0 && bus.req1) begin
                        sel_d = ~last_q;
                    end else begin
                        sel_d = bus.req1 ? REQ1 : REQ0;
                    end
                end
            end
            StGrant: state_d = StExec;
            StExec:  state_d = StDone;
            StDone: begin
                state_d = StIdle;
                last_d  = sel_q;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            sel_q    <= REQ0;
            last_q   <= REQ1;
            op_a_q   <= '0;
            op_b_q   <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            if (state_q == StGrant) begin
                op_a_q <= mux_a;
                op_b_q <= mux_b;
            end
            if (state_q == StExec) begin
                {carry_q, result_q} <= sum;
            end
        end
    end

    assign bus.gnt0      = (state_q == StGrant) && (sel_q == REQ0);
    assign bus.gnt1      = (state_q == StGrant) && (sel_q == REQ1);
    assign bus.done0     = (state_q == StDone) && (sel_q == REQ0);
    assign bus.done1     = (state_q == StDone) && (sel_q == REQ1);
    assign bus.busy      = (state_q != StIdle);
    assign bus.result    = result_q;
    assign bus.carry_out = carry_q;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Self-checking bench for adder_share_arbiter: directed vectors and sequences plus
// randomized traffic compared cycle by cycle against a behavioural model.
module tb_adder_share_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    adder_share_arbiter_if #(.WIDTH(32)) bus ();

    adder_share_arbiter #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase -1 idle, 0 grant cycle, 1 add cycle, 2 done cycle.
    int          m_ph = -1;
    bit          m_win = 1'b0;
    bit          m_last = 1'b1;
    bit          m_cy = 1'b0;
    logic [31:0] m_res = '0;
    logic [32:0] m_sum = '0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_ph   <= -1;
            m_last <= 1'b1;
            m_res  <= '0;
            m_cy   <= 1'b0;
        end else begin
            case (m_ph)
                -1: if (bus.req0 || bus.req1) begin
                    m_win <= (bus.req0 && bus.req1) ? !m_last : bus.req1;
                    m_ph  <= 0;
                end
                0: begin
                    m_sum <= m_win ? ({1'b0, bus.a1} + {1'b0, bus.b1})
                                   : ({1'b0, bus.a0} + {1'b0, bus.b0});
                    m_ph  <= 1;
                end
                1: begin
                    m_res <= m_sum[31:0];
                    m_cy  <= m_sum[32];
                    m_ph  <= 2;
                end
                default: begin
                    m_last <= m_win;
                    m_ph   <= -1;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("mdl_gnt0", {32'b0, bus.gnt0}, {32'b0, (m_ph == 0 && !m_win)});
            chk("mdl_gnt1", {32'b0, bus.gnt1}, {32'b0, (m_ph == 0 && m_win)});
            chk("mdl_done0", {32'b0, bus.done0}, {32'b0, (m_ph == 2 && !m_win)});
            chk("mdl_done1", {32'b0, bus.done1}, {32'b0, (m_ph == 2 && m_win)});
            chk("mdl_busy", {32'b0, bus.busy}, {32'b0, (m_ph != -1)});
            chk("mdl_result", {1'b0, bus.result}, {1'b0, m_res});
            chk("mdl_carry", {32'b0, bus.carry_out}, {32'b0, m_cy});
        end
    end

    typedef struct {
        bit          r0;
        bit          r1;
        logic [31:0] a0;
        logic [31:0] b0;
        logic [31:0] a1;
        logic [31:0] b1;
        bit          win;
        logic [31:0] res;
        bit          cy;
    } vec_t;

    vec_t vecs[6];

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 3))
            0:       return 32'hFFFF_FFFF;
            1:       return 32'h0;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n0, n1;
        bit order[$];
        bit hold;

        // Round-robin pointer is 1 after the simultaneous-request sequence.
        vecs[0] = '{1, 0, 32'd40, 32'd50, 32'd9, 32'd9, 0, 32'd90, 0};
        vecs[1] = '{1, 1, 32'h1234, 32'd1, 32'd100, 32'd200, 1, 32'd300, 0};
        vecs[2] = '{1, 1, 32'hFFFF_FFFF, 32'd1, 32'd5, 32'd5, 0, 32'd0, 1};
        vecs[3] = '{1, 0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'd0, 32'd0, 0, 32'hFFFF_FFFE, 0};
        vecs[4] = '{1, 1, 32'd3, 32'd4, 32'h8000_0000, 32'h8000_0001, 1, 32'd1, 1};
        vecs[5] = '{0, 1, 32'd0, 32'd0, 32'd123, 32'd456, 1, 32'd579, 0};

        bus.req0 = 1'b1; bus.req1 = 1'b1;
        bus.a0 = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0;
        #1 reset = 1'b0;
        chk_en = 1'b1;

        // Reset held with both requests high.
        repeat (5) @(negedge clk);
        chk("rst_gnt", {31'b0, bus.gnt0, bus.gnt1}, 33'd0);
        chk("rst_busy", {32'b0, bus.busy}, 33'd0);
        chk("rst_result", {bus.carry_out, bus.result}, 33'd0);
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        reset = 1'b1;
        @(negedge clk);

        // Simultaneous first request: 0 wins, 1 follows four cycles later.
        bus.req0 = 1'b1; bus.a0 = 32'd40; bus.b0 = 32'd50;
        bus.req1 = 1'b1; bus.a1 = 32'd7;  bus.b1 = 32'd8;
        @(negedge clk);
        chk("sim_gnt0", {31'b0, bus.gnt0, bus.gnt1}, 33'b10);
        bus.req0 = 1'b0;
        repeat (2) @(negedge clk);
        chk("sim_done0", {31'b0, bus.done0, bus.done1}, 33'b10);
        chk("sim_res0", {bus.carry_out, bus.result}, 33'd90);
        repeat (2) @(negedge clk);
        chk("sim_gnt1", {31'b0, bus.gnt0, bus.gnt1}, 33'b01);
        bus.req1 = 1'b0;
        repeat (2) @(negedge clk);
        chk("sim_done1", {31'b0, bus.done0, bus.done1}, 33'b01);
        chk("sim_res1", {bus.carry_out, bus.result}, 33'd15);
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            bus.req0 = vecs[i].r0; bus.req1 = vecs[i].r1;
            bus.a0 = vecs[i].a0; bus.b0 = vecs[i].b0;
            bus.a1 = vecs[i].a1; bus.b1 = vecs[i].b1;
            @(negedge clk);
            chk($sformatf("tbl%0d_gnt", i), {31'b0, bus.gnt0, bus.gnt1},
                {31'b0, !vecs[i].win, vecs[i].win});
            bus.req0 = 1'b0; bus.req1 = 1'b0;
            @(negedge clk);
            chk($sformatf("tbl%0d_exec_done", i), {31'b0, bus.done0, bus.done1}, 33'd0);
            @(negedge clk);
            chk($sformatf("tbl%0d_done", i), {31'b0, bus.done0, bus.done1},
                {31'b0, !vecs[i].win, vecs[i].win});
            chk($sformatf("tbl%0d_sum", i), {bus.carry_out, bus.result},
                {vecs[i].cy, vecs[i].res});
            @(negedge clk);
            chk($sformatf("tbl%0d_idle", i), {32'b0, bus.busy}, 33'd0);
        end

        // Reset in the middle of an operation discards it.
        bus.req0 = 1'b1; bus.a0 = 32'd40; bus.b0 = 32'd50;
        @(negedge clk);
        bus.req0 = 1'b0;
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_flags", {29'b0, bus.gnt0, bus.gnt1, bus.done0, bus.done1}, 33'd0);
        chk("mid_rst_busy", {32'b0, bus.busy}, 33'd0);
        chk("mid_rst_result", {bus.carry_out, bus.result}, 33'd0);
        @(negedge clk);
        reset = 1'b1;
        n0 = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.done0 || bus.done1) n0++;
        end
        chk("mid_rst_nodone", 33'(n0), 33'd0);
        bus.req1 = 1'b1; bus.a1 = 32'd7; bus.b1 = 32'd8;
        @(negedge clk);
        chk("post_rst_gnt1", {31'b0, bus.gnt0, bus.gnt1}, 33'b01);
        bus.req1 = 1'b0;
        repeat (2) @(negedge clk);
        chk("post_rst_done1", {31'b0, bus.done0, bus.done1}, 33'b01);
        chk("post_rst_sum", {bus.carry_out, bus.result}, 33'd15);
        @(negedge clk);

        // Fairness: both held for 16 cycles, grants alternate starting with 0.
        bus.req0 = 1'b1; bus.a0 = 32'd1; bus.b0 = 32'd2;
        bus.req1 = 1'b1; bus.a1 = 32'd3; bus.b1 = 32'd4;
        n0 = 0; n1 = 0;
        repeat (16) begin
            @(negedge clk);
            if (bus.gnt0) order.push_back(1'b0);
            if (bus.gnt1) order.push_back(1'b1);
            if (bus.done0) n0++;
            if (bus.done1) n1++;
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        chk("fair_ngrants", 33'(order.size()), 33'd4);
        for (int i = 0; i < order.size() && i < 4; i++) begin
            chk($sformatf("fair_order%0d", i), {32'b0, order[i]}, {32'b0, i[0]});
        end
        chk("fair_done0", 33'(n0), 33'd2);
        chk("fair_done1", 33'(n1), 33'd2);
        repeat (2) @(negedge clk);

        // Randomized traffic; operands only change while that requester is idle.
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            hold = (m_ph == 0 && !m_win);
            if (bus.req0) begin
                if ($urandom_range(0, hold ? 1 : 15) == 0) bus.req0 = 1'b0;
            end else if (!hold && $urandom_range(0, 2) == 0) begin
                bus.req0 = 1'b1; bus.a0 = rnd_op(); bus.b0 = rnd_op();
            end
            hold = (m_ph == 0 && m_win);
            if (bus.req1) begin
                if ($urandom_range(0, hold ? 1 : 15) == 0) bus.req1 = 1'b0;
            end else if (!hold && $urandom_range(0, 2) == 0) begin
                bus.req1 = 1'b1; bus.a1 = rnd_op(); bus.b1 = rnd_op();
            end
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        repeat (6) @(negedge clk);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
